// File: rtl/serve_sequencer_pkg.sv
// Shared rally-sequencing definitions: FSM states, side encoding and
// serve/field coordinates used by the judge, ball and sequencer blocks.
package serve_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_COUNT,
        ST_SERVE,
        ST_RALLY,
        ST_HOLD,
        ST_OVER
    } state_t;

    typedef enum logic {
        SIDE_P1 = 1'b0,
        SIDE_P2 = 1'b1
    } side_t;

    localparam int unsigned COORD_W     = 12;
    localparam int unsigned CLK_FREQ    = 65_000_000;
    localparam int unsigned TICK_HZ     = 100;
    localparam int unsigned HOLD_TICKS  = 150;
    localparam int unsigned DIGIT_TICKS = 100;
    localparam int unsigned COUNT_FROM  = 3;
    localparam int unsigned SERVE_X1    = 200;
    localparam int unsigned SERVE_X2    = 823;
    localparam int unsigned SERVE_Y     = 300;
    localparam int unsigned FIELD_MID   = 512;

    function automatic logic [COORD_W-1:0] serve_x(
        input logic               side,
        input logic [COORD_W-1:0] x1,
        input logic [COORD_W-1:0] x2
    );
        return (side == SIDE_P2) ? x2 : x1;
    endfunction

endpackage

// File: rtl/serve_sequencer_tick.sv
// Free-running time base: one-cycle tick every CLK_FREQ/TICK_HZ clocks,
// restartable so a new state always waits a full period for its first tick.
module tick_gen #(
    parameter int unsigned CLK_FREQ = 65_000_000,
    parameter int unsigned TICK_HZ  = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned PERIOD = CLK_FREQ / TICK_HZ;
    localparam int unsigned CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == CW'(PERIOD - 1));
        cnt_d = cnt_q + CW'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serve_sequencer.sv
// Rally sequencer: freeze, place ball at the server, count down, release;
// all outputs are registered from the current state.
module serve_sequencer
    import serve_sequencer_pkg::*;
#(
    parameter int unsigned CLK_FREQ    = serve_sequencer_pkg::CLK_FREQ,
    parameter int unsigned TICK_HZ     = serve_sequencer_pkg::TICK_HZ,
    parameter int unsigned HOLD_TICKS  = serve_sequencer_pkg::HOLD_TICKS,
    parameter int unsigned DIGIT_TICKS = serve_sequencer_pkg::DIGIT_TICKS,
    parameter int unsigned COUNT_FROM  = serve_sequencer_pkg::COUNT_FROM,
    parameter int unsigned SERVE_X1    = serve_sequencer_pkg::SERVE_X1,
    parameter int unsigned SERVE_X2    = serve_sequencer_pkg::SERVE_X2,
    parameter int unsigned SERVE_Y     = serve_sequencer_pkg::SERVE_Y
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        point_pulse,
    input  logic        flag_point,
    input  logic        endgame,
    input  logic        ball_touched,
    output logic        ball_hold,
    output logic        ball_load,
    output logic [11:0] ball_x_init,
    output logic [11:0] ball_y_init,
    output logic        players_freeze,
    output logic        serve_side,
    output logic [3:0]  countdown,
    output logic        game_over
);

    localparam int unsigned MAXT = (HOLD_TICKS > DIGIT_TICKS) ? HOLD_TICKS : DIGIT_TICKS;
    localparam int unsigned TW   = $clog2(MAXT + 1);

    state_t        state_q, state_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [3:0]    digit_q, digit_d;
    logic          side_q, side_d;
    logic          hold_q, hold_d;
    logic          load_q, load_d;
    logic          freeze_q, freeze_d;
    logic          over_q, over_d;
    logic [3:0]    cd_q, cd_d;
    logic [11:0]   x_q, x_d;
    logic [11:0]   y_q, y_d;
    logic          tick;
    logic          clr;

    tick_gen #(
        .CLK_FREQ (CLK_FREQ),
        .TICK_HZ  (TICK_HZ)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        digit_d = digit_q;
        side_d  = side_q;
        unique case (state_q)
            ST_LOAD: begin
                state_d = ST_COUNT;
                digit_d = 4'(COUNT_FROM);
            end
            ST_COUNT: begin
                if (tick) begin
                    if (tcnt_q == TW'(DIGIT_TICKS - 1)) begin
                        tcnt_d = '0;
                        if (digit_q <= 4'd1) begin
                            state_d = ST_SERVE;
                        end else begin
                            digit_d = digit_q - 4'd1;
                        end
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
            end
            ST_SERVE: begin
                if (point_pulse) begin
                    side_d  = flag_point;
                    state_d = ST_HOLD;
                end else if (ball_touched) begin
                    state_d = ST_RALLY;
                end
            end
            ST_RALLY: begin
                if (point_pulse) begin
                    side_d  = flag_point;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    if (tcnt_q == TW'(HOLD_TICKS - 1)) begin
                        state_d = ST_LOAD;
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
            end
            ST_OVER: begin
                state_d = ST_OVER;
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
        if (endgame) begin
            state_d = ST_OVER;
        end
        // Every state starts with fresh time base and tick count.
        clr = (state_d != state_q);
        if (clr) begin
            tcnt_d = '0;
        end
    end

    always_comb begin
        hold_d   = (state_q != ST_RALLY);
        freeze_d = !((state_q == ST_SERVE) || (state_q == ST_RALLY));
        load_d   = (state_q == ST_LOAD);
        over_d   = (state_q == ST_OVER);
        cd_d     = (state_q == ST_COUNT) ? digit_q : 4'd0;
        x_d      = x_q;
        y_d      = 12'(SERVE_Y);
        if (state_q == ST_LOAD) begin
            x_d = serve_x(side_q, 12'(SERVE_X1), 12'(SERVE_X2));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_LOAD;
            tcnt_q   <= '0;
            digit_q  <= '0;
            side_q   <= SIDE_P1;
            hold_q   <= 1'b1;
            load_q   <= 1'b0;
            freeze_q <= 1'b1;
            over_q   <= 1'b0;
            cd_q     <= '0;
            x_q      <= 12'(SERVE_X1);
            y_q      <= 12'(SERVE_Y);
        end else begin
            state_q  <= state_d;
            tcnt_q   <= tcnt_d;
            digit_q  <= digit_d;
            side_q   <= side_d;
            hold_q   <= hold_d;
            load_q   <= load_d;
            freeze_q <= freeze_d;
            over_q   <= over_d;
            cd_q     <= cd_d;
            x_q      <= x_d;
            y_q      <= y_d;
        end
    end

    assign ball_hold      = hold_q;
    assign ball_load      = load_q;
    assign ball_x_init    = x_q;
    assign ball_y_init    = y_q;
    assign players_freeze = freeze_q;
    assign serve_side     = side_q;
    assign countdown      = cd_q;
    assign game_over      = over_q;

endmodule

// File: tb/tb_serve_sequencer.sv
// Bench for serve_sequencer: cycle-count reference model checked every
// cycle, directed rally scenarios plus randomized input traffic.
module tb_serve_sequencer;

    localparam int P          = 10;
    localparam int DIGIT_CLKS = 2 * P;
    localparam int HOLD_CLKS  = 5 * P;
    localparam int CNT_CLKS   = 3 * DIGIT_CLKS;

    localparam int M_LOAD  = 0;
    localparam int M_COUNT = 1;
    localparam int M_SERVE = 2;
    localparam int M_RALLY = 3;
    localparam int M_HOLD  = 4;
    localparam int M_OVER  = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        point_pulse;
    logic        flag_point;
    logic        endgame;
    logic        ball_touched;
    logic        ball_hold;
    logic        ball_load;
    logic [11:0] ball_x_init;
    logic [11:0] ball_y_init;
    logic        players_freeze;
    logic        serve_side;
    logic [3:0]  countdown;
    logic        game_over;

    int checks = 0;
    int errors = 0;

    serve_sequencer #(
        .CLK_FREQ    (1000),
        .TICK_HZ     (100),
        .HOLD_TICKS  (5),
        .DIGIT_TICKS (2),
        .COUNT_FROM  (3),
        .SERVE_X1    (200),
        .SERVE_X2    (823),
        .SERVE_Y     (300)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .point_pulse    (point_pulse),
        .flag_point     (flag_point),
        .endgame        (endgame),
        .ball_touched   (ball_touched),
        .ball_hold      (ball_hold),
        .ball_load      (ball_load),
        .ball_x_init    (ball_x_init),
        .ball_y_init    (ball_y_init),
        .players_freeze (players_freeze),
        .serve_side     (serve_side),
        .countdown      (countdown),
        .game_over      (game_over)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase plus clocks spent in it.
    int m_st, m_age, m_side, nxt;
    int e_hold, e_load, e_frz, e_cd, e_over, e_x;
    bit chk_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_st   = M_LOAD;
            m_age  = 0;
            m_side = 0;
            e_hold = 1;
            e_load = 0;
            e_frz  = 1;
            e_cd   = 0;
            e_over = 0;
            e_x    = 200;
            chk_en = 1'b1;
        end else begin
            e_load = (m_st == M_LOAD) ? 1 : 0;
            e_hold = (m_st == M_RALLY) ? 0 : 1;
            e_frz  = (m_st == M_SERVE || m_st == M_RALLY) ? 0 : 1;
            e_over = (m_st == M_OVER) ? 1 : 0;
            e_cd   = (m_st == M_COUNT) ? 3 - m_age / DIGIT_CLKS : 0;
            if (m_st == M_LOAD) e_x = m_side ? 823 : 200;
            nxt = m_st;
            m_age++;
            case (m_st)
                M_LOAD:  nxt = M_COUNT;
                M_COUNT: if (m_age == CNT_CLKS) nxt = M_SERVE;
                M_SERVE: begin
                    if (point_pulse) begin
                        m_side = int'(flag_point);
                        nxt = M_HOLD;
                    end else if (ball_touched) begin
                        nxt = M_RALLY;
                    end
                end
                M_RALLY: begin
                    if (point_pulse) begin
                        m_side = int'(flag_point);
                        nxt = M_HOLD;
                    end
                end
                M_HOLD:  if (m_age == HOLD_CLKS) nxt = M_LOAD;
                default: nxt = m_st;
            endcase
            if (endgame) nxt = M_OVER;
            if (nxt != m_st) begin
                m_st  = nxt;
                m_age = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ball_hold", int'(ball_hold), e_hold);
            chk("ball_load", int'(ball_load), e_load);
            chk("players_freeze", int'(players_freeze), e_frz);
            chk("countdown", int'(countdown), e_cd);
            chk("game_over", int'(game_over), e_over);
            chk("ball_x_init", int'(ball_x_init), e_x);
            chk("ball_y_init", int'(ball_y_init), 300);
            chk("serve_side", int'(serve_side), m_side);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic idle();
        point_pulse  = 1'b0;
        flag_point   = 1'b0;
        endgame      = 1'b0;
        ball_touched = 1'b0;
    endtask

    task automatic wait_serve(input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (players_freeze && n < limit);
        if (players_freeze) chk("serve_timeout", 1, 0);
    endtask

    int n;

    initial begin
        rst = 1'b1;
        idle();
        cyc(3);
        chk("rst_hold", int'(ball_hold), 1);
        chk("rst_freeze", int'(players_freeze), 1);
        chk("rst_load", int'(ball_load), 0);
        chk("rst_x", int'(ball_x_init), 200);
        chk("rst_cd", int'(countdown), 0);
        rst = 1'b0;

        cyc(1);
        chk("t1_load", int'(ball_load), 1);
        cyc(1);
        chk("t1_cd3", int'(countdown), 3);
        chk("t1_load_end", int'(ball_load), 0);
        cyc(20);
        chk("t1_cd2", int'(countdown), 2);
        cyc(39);
        chk("t1_cd1", int'(countdown), 1);
        cyc(1);
        chk("t1_serve_cd", int'(countdown), 0);
        chk("t1_serve_frz", int'(players_freeze), 0);
        chk("t1_serve_hold", int'(ball_hold), 1);

        ball_touched = 1'b1;
        cyc(1);
        ball_touched = 1'b0;
        cyc(1);
        chk("t2_hold", int'(ball_hold), 0);
        chk("t2_frz", int'(players_freeze), 0);

        point_pulse = 1'b1;
        flag_point  = 1'b1;
        cyc(1);
        idle();
        n = 0;
        do begin
            @(negedge clk);
            n++;
            point_pulse = (n == 20);
            flag_point  = 1'b0;
        end while (!ball_load && n < 200);
        idle();
        chk("t3_hold_len", n, 51);
        chk("t3_x", int'(ball_x_init), 823);
        chk("t3_side", int'(serve_side), 1);

        n = 0;
        do begin
            @(negedge clk);
            n++;
            point_pulse = (n == 5 || n == 30);
            flag_point  = 1'b0;
        end while (players_freeze && n < 200);
        idle();
        chk("t4_count_len", n, 61);
        chk("t4_side", int'(serve_side), 1);

        point_pulse  = 1'b1;
        ball_touched = 1'b1;
        flag_point   = 1'b0;
        cyc(1);
        idle();
        cyc(1);
        chk("t5_hold", int'(ball_hold), 1);
        chk("t5_frz", int'(players_freeze), 1);
        chk("t5_side", int'(serve_side), 0);
        cyc(25);
        chk("t5_still_hold", int'(ball_hold), 1);

        for (int i = 0; i < 6000; i++) begin
            rst          = ($urandom_range(299) == 0);
            point_pulse  = ($urandom_range(7) == 0);
            flag_point   = 1'($urandom);
            ball_touched = ($urandom_range(3) == 0);
            endgame      = ($urandom_range(499) == 0);
            cyc(1);
        end
        rst = 1'b1;
        idle();
        cyc(2);
        rst = 1'b0;

        cyc(30);
        endgame = 1'b1;
        cyc(1);
        endgame = 1'b0;
        cyc(1);
        chk("t6_over", int'(game_over), 1);
        cyc(100);
        chk("t6_sticky", int'(game_over), 1);
        chk("t6_cd", int'(countdown), 0);

        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        wait_serve(200, n);
        ball_touched = 1'b1;
        cyc(1);
        ball_touched = 1'b0;
        cyc(3);
        chk("t6_rally", int'(ball_hold), 0);
        rst = 1'b1;
        cyc(1);
        chk("t6_rst_hold", int'(ball_hold), 1);
        chk("t6_rst_frz", int'(players_freeze), 1);
        chk("t6_rst_load", int'(ball_load), 0);
        chk("t6_rst_over", int'(game_over), 0);
        rst = 1'b0;
        cyc(1);
        chk("t6_reload", int'(ball_load), 1);
        cyc(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
